// File: rtl/deskew_pkg.sv
// Shared constants for the PCS lane deskew alignment monitor.
package deskew_pkg;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_ALIGNED  = 3'd3;
    localparam logic [2:0] ST_RESYNC   = 3'd4;

    localparam int DEF_N_LANES   = 20;
    localparam int DEF_AM_PERIOD = 16384;

endpackage

// File: rtl/deskew_align_monitor_tracker.sv
// Alignment-marker period tracker: anchors on the first all-lane tag event
// and classifies each valid cycle as a good or bad AM event.
module am_period_tracker
    import deskew_pkg::*;
#(
    parameter int N_LANES   = DEF_N_LANES,
    parameter int AM_PERIOD = DEF_AM_PERIOD,
    parameter int NB_PERIOD = $clog2(AM_PERIOD)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic               i_active,
    input  logic [N_LANES-1:0] i_sol_tags,
    output logic               o_good_event,
    output logic               o_bad_event
);

    localparam logic [NB_PERIOD-1:0] LP_LAST = NB_PERIOD'(AM_PERIOD - 1);

    logic [NB_PERIOD-1:0] r_cnt;
    logic                 r_anchor;
    logic                 w_step;
    logic                 w_any;
    logic                 w_all;
    logic                 w_slot;

    assign w_step = i_enable & i_active & i_valid;
    assign w_any  = |i_sol_tags;
    assign w_all  = &i_sol_tags;
    assign w_slot = (r_cnt == LP_LAST);

    // Before anchoring there is no slot: only partial events count as bad.
    assign o_good_event = w_step & w_all & (~r_anchor | w_slot);
    assign o_bad_event  = w_step & (r_anchor ? (w_slot ? ~w_all : w_any)
                                             : (w_any & ~w_all));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_anchor <= 1'b0;
        end else if (i_enable) begin
            if (!i_active) begin
                r_cnt    <= '0;
                r_anchor <= 1'b0;
            end else if (i_valid) begin
                if (!r_anchor) begin
                    if (w_all) begin
                        r_anchor <= 1'b1;
                        r_cnt    <= '0;
                    end
                end else begin
                    r_cnt <= w_slot ? '0 : r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/deskew_align_monitor.sv
// Post-deskew alignment supervisor: verifies per-period AM alignment across
// all lanes, reports align status and requests resync on failure.
module deskew_align_monitor
    import deskew_pkg::*;
#(
    parameter int N_LANES       = DEF_N_LANES,
    parameter int AM_PERIOD     = DEF_AM_PERIOD,
    parameter int NB_PERIOD     = $clog2(AM_PERIOD),
    parameter int N_GOOD        = 4,
    parameter int N_BAD         = 3,
    parameter int DONE_TIMEOUT  = 4 * AM_PERIOD,
    parameter int NB_TIMEOUT    = $clog2(DONE_TIMEOUT + 1),
    parameter int RESYNC_CYCLES = 4,
    parameter int NB_ERR        = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic               i_deskew_done,
    input  logic               i_invalid_skew,
    input  logic [N_LANES-1:0] i_sol_tags,
    output logic [N_LANES-1:0] o_resync,
    output logic               o_align_status,
    output logic [NB_ERR-1:0]  o_error_count,
    output logic [2:0]         o_state
);

    localparam int NB_GOOD = $clog2(N_GOOD + 1);
    localparam int NB_BAD  = $clog2(N_BAD + 1);
    localparam int NB_RS   = $clog2(RESYNC_CYCLES + 1);

    logic [2:0]            r_state;
    logic [NB_TIMEOUT-1:0] r_tmo;
    logic [NB_GOOD-1:0]    r_good;
    logic [NB_BAD-1:0]     r_bad;
    logic [NB_RS-1:0]      r_rs_cnt;
    logic [NB_ERR-1:0]     r_err;
    logic                  r_align;
    logic [N_LANES-1:0]    r_resync;
    logic                  w_active;
    logic                  w_good;
    logic                  w_bad;
    logic                  w_err_max;

    assign w_active  = (r_state == ST_CHECK) || (r_state == ST_ALIGNED);
    assign w_err_max = (r_err == {NB_ERR{1'b1}});

    am_period_tracker #(
        .N_LANES   (N_LANES),
        .AM_PERIOD (AM_PERIOD),
        .NB_PERIOD (NB_PERIOD)
    ) u_tracker (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .i_active     (w_active),
        .i_sol_tags   (i_sol_tags),
        .o_good_event (w_good),
        .o_bad_event  (w_bad)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_INIT;
            r_tmo    <= '0;
            r_good   <= '0;
            r_bad    <= '0;
            r_rs_cnt <= '0;
            r_err    <= '0;
            r_align  <= 1'b0;
            r_resync <= '0;
        end else if (i_enable) begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_invalid_skew) begin
                        r_state  <= ST_RESYNC;
                        r_resync <= '1;
                        r_rs_cnt <= '0;
                    end else if (i_deskew_done) begin
                        r_state <= ST_CHECK;
                        r_good  <= '0;
                        r_bad   <= '0;
                    end else if (i_valid) begin
                        if (r_tmo == NB_TIMEOUT'(DONE_TIMEOUT - 1)) begin
                            r_state  <= ST_RESYNC;
                            r_resync <= '1;
                            r_rs_cnt <= '0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                ST_CHECK, ST_ALIGNED: begin
                    // Losing deskew done returns to waiting without a resync.
                    if (!i_deskew_done) begin
                        r_state <= ST_WAIT;
                        r_align <= 1'b0;
                        r_tmo   <= '0;
                        r_good  <= '0;
                        r_bad   <= '0;
                    end else if (w_good) begin
                        r_bad <= '0;
                        if (r_state == ST_CHECK) begin
                            if (r_good == NB_GOOD'(N_GOOD - 1)) begin
                                r_state <= ST_ALIGNED;
                                r_align <= 1'b1;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end
                    end else if (w_bad) begin
                        r_good <= '0;
                        if (!w_err_max)
                            r_err <= r_err + 1'b1;
                        if (r_bad == NB_BAD'(N_BAD - 1)) begin
                            r_state  <= ST_RESYNC;
                            r_align  <= 1'b0;
                            r_resync <= '1;
                            r_rs_cnt <= '0;
                        end else begin
                            r_bad <= r_bad + 1'b1;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (r_rs_cnt == NB_RS'(RESYNC_CYCLES - 1)) begin
                        r_state  <= ST_WAIT;
                        r_resync <= '0;
                        r_tmo    <= '0;
                        r_good   <= '0;
                        r_bad    <= '0;
                    end else begin
                        r_rs_cnt <= r_rs_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign o_state        = r_state;
    assign o_align_status = r_align;
    assign o_error_count  = r_err;
    assign o_resync       = r_resync;

endmodule

// File: tb/tb_deskew_align_monitor.sv
// Directed bench for deskew_align_monitor with a small AM period.
module tb_deskew_align_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid;
    logic        done;
    logic        skew;
    logic [3:0]  tags;
    logic [3:0]  resync;
    logic        align;
    logic [15:0] err;
    logic [2:0]  state;

    int n_total = 0;
    int n_bad   = 0;
    int clk_cnt = 0;

    always #5 clk = ~clk;

    deskew_align_monitor #(
        .N_LANES       (4),
        .AM_PERIOD     (8),
        .NB_PERIOD     (3),
        .N_GOOD        (4),
        .N_BAD         (3),
        .DONE_TIMEOUT  (32),
        .NB_TIMEOUT    (6),
        .RESYNC_CYCLES (4),
        .NB_ERR        (16)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_valid        (valid),
        .i_deskew_done  (done),
        .i_invalid_skew (skew),
        .i_sol_tags     (tags),
        .o_resync       (resync),
        .o_align_status (align),
        .o_error_count  (err),
        .o_state        (state)
    );

    typedef struct {
        logic        done;
        logic        skew;
        logic [3:0]  tags;
        logic [2:0]  st;
        logic        al;
        logic [3:0]  rs;
        logic [15:0] err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clk_cnt++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b1;
        done  = 1'b0;
        skew  = 1'b0;
        tags  = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
    endtask

    // One valid cycle, optionally preceded by an invalid cycle carrying tags.
    task automatic vcycle(input bit gap, input logic [3:0] t);
        if (gap) begin
            valid = 1'b0;
            tags  = 4'hF;
            tick();
        end
        valid = 1'b1;
        tags  = t;
        tick();
        tags  = 4'h0;
    endtask

    task automatic go_check();
        done = 1'b0;
        tick();
        chk("init_to_wait", state, 1);
        done = 1'b1;
        tick();
        chk("wait_to_check", state, 2);
    endtask

    task automatic run_lock(input bit gap, input int exp_clk);
        clk_cnt = 0;
        vcycle(gap, 4'hF);
        for (int i = 1; i <= 64; i++) begin
            vcycle(gap, (i % 8 == 0) ? 4'hF : 4'h0);
            if (i == 16)
                chk("lock_not_yet", align, 0);
            if (align)
                break;
        end
        chk("lock_align", align, 1);
        chk("lock_state", state, 3);
        chk("lock_clocks", clk_cnt, exp_clk);
        chk("lock_err", err, 0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 4'h0, 3'd1, 1'b0, 4'h0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 4'h0, 3'd4, 1'b0, 4'hF, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 4'hF, 16'd0};
        tbl[3] = '{1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 4'hF, 16'd0};
        tbl[4] = '{1'b1, 1'b0, 4'h0, 3'd4, 1'b0, 4'hF, 16'd0};
        tbl[5] = '{1'b1, 1'b0, 4'h0, 3'd1, 1'b0, 4'h0, 16'd0};
        tbl[6] = '{1'b1, 1'b0, 4'h0, 3'd2, 1'b0, 4'h0, 16'd0};
        tbl[7] = '{1'b1, 1'b0, 4'hD, 3'd2, 1'b0, 4'h0, 16'd1};
        tbl[8] = '{1'b1, 1'b0, 4'hF, 3'd2, 1'b0, 4'h0, 16'd1};
        tbl[9] = '{1'b0, 1'b0, 4'h0, 3'd1, 1'b0, 4'h0, 16'd1};

        do_reset();
        chk("rst_state", state, 0);
        chk("rst_align", align, 0);
        chk("rst_resync", resync, 0);
        chk("rst_err", err, 0);

        // Priority of invalid skew, resync length, pre-anchor partial.
        for (int i = 0; i < 10; i++) begin
            done = tbl[i].done;
            skew = tbl[i].skew;
            tags = tbl[i].tags;
            tick();
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_align", i), align, tbl[i].al);
            chk($sformatf("tbl%0d_resync", i), resync, tbl[i].rs);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
        end
        skew = 1'b0;
        tags = 4'h0;

        // Deskew-done timeout.
        done = 1'b0;
        for (int i = 0; i < 31; i++)
            tick();
        chk("tmo_wait", state, 1);
        tick();
        chk("tmo_resync_state", state, 4);
        begin
            int n_hi;
            n_hi = (resync == 4'hF) ? 1 : 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (resync == 4'hF)
                    n_hi++;
                else
                    break;
            end
            chk("tmo_resync_len", n_hi, 4);
            chk("tmo_back_wait", state, 1);
        end

        // Lock, then misalignment in three consecutive slots.
        do_reset();
        go_check();
        run_lock(1'b0, 25);
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 7; i++)
                vcycle(1'b0, 4'h0);
            vcycle(1'b0, 4'hD);
            chk($sformatf("mis%0d_err", k), err, k);
            chk($sformatf("mis%0d_align", k), align, (k < 3) ? 1 : 0);
            chk($sformatf("mis%0d_state", k), state, (k < 3) ? 3 : 4);
        end
        chk("mis_resync", resync, 4'hF);

        // Reset mid-resync is immediate.
        tick();
        chk("midrs_resync", resync, 4'hF);
        rst = 1'b1;
        #1;
        chk("async_rst_resync", resync, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_err", err, 0);

        // Early event then missing slot keep ALIGNED; one more bad resyncs.
        do_reset();
        go_check();
        run_lock(1'b0, 25);
        for (int i = 0; i < 5; i++)
            vcycle(1'b0, 4'h0);
        vcycle(1'b0, 4'hF);
        chk("early_err", err, 1);
        vcycle(1'b0, 4'h0);
        vcycle(1'b0, 4'h0);
        chk("missing_err", err, 2);
        chk("missing_state", state, 3);
        chk("missing_align", align, 1);
        for (int i = 0; i < 8; i++)
            vcycle(1'b0, 4'h0);
        chk("third_bad_state", state, 4);
        chk("third_bad_err", err, 3);
        chk("third_bad_align", align, 0);

        // Half-rate valid doubles lock time; then drop deskew done.
        do_reset();
        go_check();
        run_lock(1'b1, 50);
        done = 1'b0;
        tick();
        chk("drop_state", state, 1);
        chk("drop_align", align, 0);
        chk("drop_resync", resync, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/deskew_align_monitor.md
Name: deskew_align_monitor

Overview:
- Supervises the 100GbE PCS lane deskew stage after it reports completion.
- Watches the per-lane start-of-lane tags leaving the programmable deskew FIFOs and checks that all lanes present an alignment marker on the same valid cycle, once every AM period.
- Raises align status after enough consecutive good periods.
- Drives resync back into the deskew stage on timeout, invalid skew, or repeated misalignment.

Parameters:
- N_LANES, 20, number of PCS lanes
- AM_PERIOD, 16384, valid cycles between consecutive alignment markers per lane
- NB_PERIOD, $clog2(AM_PERIOD), width of the period counter
- N_GOOD, 4, consecutive good AM events required to declare alignment
- N_BAD, 3, consecutive bad AM events that trigger resync
- DONE_TIMEOUT, 4*AM_PERIOD, maximum valid cycles to wait for deskew done
- NB_TIMEOUT, $clog2(DONE_TIMEOUT+1), width of the timeout counter
- RESYNC_CYCLES, 4, clock cycles the resync output is held
- NB_ERR, 16, width of the error counter

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state, counters and outputs
- i_valid  in  1  datapath valid qualifier
- i_deskew_done  in  1  deskew stage has programmed its FIFO delays
- i_invalid_skew  in  1  deskew stage measured skew beyond MAX_SKEW
- i_sol_tags  in  N_LANES  start-of-lane tag bit of each FIFO output word, lane 0 at the MSB
- o_resync  out  N_LANES  resync request per lane; all bits are always equal
- o_align_status  out  1  lanes verified aligned
- o_error_count  out  NB_ERR  saturating count of bad AM events
- o_state  out  3  current FSM state, for debug

Behaviour:
- Reset values: o_resync=0, o_align_status=0, o_error_count=0, state=INIT, all internal counters=0.
- Outputs are registered. A state change is visible one clock after the deciding input.
- Tag event: a valid cycle with |i_sol_tags=1. A good event has &i_sol_tags=1. Any other tag event is partial, and partial events are bad.
- Period counter: advances on valid cycles only and wraps at AM_PERIOD-1 to 0. It is cleared to 0 on the anchor event.
- Expected slot: the valid cycle on which the counter equals AM_PERIOD-1.
  - A tag event outside the expected slot is bad (early).
  - No tag event in the expected slot is bad (missing).
  - A good event in the expected slot is good.
- FSM states:
  - INIT: go to WAIT_DESKEW when i_enable=1.
  - WAIT_DESKEW: the timeout counter counts valid cycles.
    - i_deskew_done=1 → CHECK, with the anchor cleared.
    - i_invalid_skew=1 or timeout reaching DONE_TIMEOUT → RESYNC.
    - If i_invalid_skew and i_deskew_done are both 1 in the same cycle, i_invalid_skew wins.
  - CHECK: before an anchor exists, the first good event sets the anchor and good_cnt=1.
    - Each subsequent good event increments good_cnt. Reaching N_GOOD → ALIGNED.
    - A bad event clears good_cnt, increments bad_cnt and o_error_count. Reaching N_BAD → RESYNC.
    - A bad event before the anchor leaves the anchor unset.
  - ALIGNED: o_align_status=1.
    - A good event clears bad_cnt.
    - A bad event increments bad_cnt and o_error_count. Reaching N_BAD → RESYNC.
    - o_align_status stays 1 until the transition.
  - RESYNC: o_resync is all ones for RESYNC_CYCLES clocks, counted regardless of i_valid. Then → WAIT_DESKEW with the timeout counter, good_cnt and bad_cnt cleared.
  - In any state other than INIT and RESYNC, i_deskew_done falling → WAIT_DESKEW. This clears o_align_status and the anchor, and does not issue a resync.
- o_error_count saturates at all ones. It is cleared only by reset.
- o_align_status falls on the same edge as the entry to RESYNC or WAIT_DESKEW.
- i_valid=0 holds the period, timeout, good and bad counters. Only the RESYNC duration counter keeps counting.
- Asynchronous reset at any time returns every register to its reset value immediately, including mid-RESYNC.

Decomposition:
- Shared package deskew_pkg: state encodings (INIT=0, WAIT_DESKEW=1, CHECK=2, ALIGNED=3, RESYNC=4) and the default AM_PERIOD/N_LANES constants.
- Sub-module am_period_tracker: holds the period counter and anchor flag. It outputs good_event and bad_event, which are mutually exclusive single-cycle pulses.
- The FSM and the counters of deskew_align_monitor instantiate am_period_tracker.

Test Plan (bench uses AM_PERIOD=8, N_LANES=4, N_GOOD=4, N_BAD=3, DONE_TIMEOUT=32, RESYNC_CYCLES=4, i_valid=1 unless stated):
- Lock: deskew_done=1, then tags=4'b1111 every 8 cycles → o_align_status rises one clock after the 4th good event, and o_error_count=0.
- Timeout: deskew_done held 0 for 32 valid cycles → o_resync=4'b1111 for exactly 4 clocks, then state=WAIT_DESKEW.
- Misalignment: after ALIGNED, send tags=4'b1101 in 3 consecutive expected slots → align_status falls, o_resync pulses, o_error_count=3.
- Early/missing: after ALIGNED, send one event at count 5 and none at 7 → error_count +2 and ALIGNED kept. One further bad event → RESYNC.
- Valid gating and reset: toggle i_valid 50% → lock takes twice the clocks. Assert i_reset mid-RESYNC → o_resync=0 immediately and state=INIT.
- Priority: i_invalid_skew and i_deskew_done rise together in WAIT_DESKEW → RESYNC entered, not CHECK.
